// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-captured bytes with parity/frame flags, FWFT read port.
// Optional macro RX_FIFO_ERRDROP_EN drops flagged bytes and counts them in err_cnt.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              enable_fifo,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  input  logic              wr_perr,
  input  logic              wr_ferr,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_perr,
  output logic              rd_ferr,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    sat_inc8 = (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wv_p0;
  logic              cap;
  logic              has_err;
  logic              pop;
  logic              push;
  logic              drop;

  assign cap   = wr_valid & ~wv_p0;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = rd_en & ~empty;

`ifdef RX_FIFO_ERRDROP_EN
  assign has_err = wr_perr | wr_ferr;
`else
  assign has_err = 1'b0;
`endif

  // A pop in the same cycle frees the slot the write lands in (wr_ptr == rd_ptr when full).
  assign push = cap & ~has_err & (~full | pop);
  assign drop = cap & ~has_err & full & ~pop;

  assign {rd_ferr, rd_perr, rd_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_ferr, wr_perr, wr_data};
  end

  always_ff @(posedge clk) begin
    if (!enable_fifo) begin
      wv_p0   <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      wv_p0 <= wr_valid;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef RX_FIFO_ERRDROP_EN
  always_ff @(posedge clk) begin
    if (!enable_fifo)         err_cnt <= '0;
    else if (cap && has_err)  err_cnt <= sat_inc8(err_cnt);
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; follows RX_FIFO_ERRDROP_EN when defined for the build.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       enable_fifo;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_perr;
  logic       wr_ferr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       rd_ferr;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .enable_fifo(enable_fifo), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_perr(wr_perr), .wr_ferr(wr_ferr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_perr(rd_perr), .rd_ferr(rd_ferr), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .clr_overrun(clr_overrun), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One wr_valid pulse: high for a cycle (captured), then low for a cycle.
  task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe);
    wr_data = d; wr_perr = pe; wr_ferr = fe; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0; wr_perr = 1'b0; wr_ferr = 1'b0;
    tick();
  endtask

  task automatic pop_once();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  logic [7:0] prev;
  logic [7:0] nxt;

  initial begin
    enable_fifo = 1'b0; wr_data = 8'h00; wr_valid = 1'b1; wr_perr = 1'b0;
    wr_ferr = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    enable_fifo = 1'b1;
    tick(); tick();
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_errcnt", err_cnt, 0);

    wr_valid = 1'b0; tick();
    wr_data = 8'hA5; wr_valid = 1'b1; tick();
    chk("first_count", count, 1);
    chk("first_data", rd_data, 8'hA5);
    chk("first_empty", empty, 0);
    wr_valid = 1'b0;
    pop_once();
    chk("first_pop_empty", empty, 1);

    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovr0", overrun, 0);
    send_byte(8'h55, 1'b0, 1'b0);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", rd_data, 32'(i));
      pop_once();
    end
    chk("drain_empty", empty, 1);
    chk("drain_ovr_sticky", overrun, 1);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    chk("ovr_clr", overrun, 0);

    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
    wr_data = 8'h77; wr_valid = 1'b1; rd_en = 1'b1;
    tick();
    wr_valid = 1'b0; rd_en = 1'b0;
    chk("fullpop_count", count, 16);
    chk("fullpop_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      chk("fullpop_data", rd_data, (i < 15) ? 32'(i + 1) : 32'h77);
      pop_once();
    end
    chk("fullpop_empty", empty, 1);

    tick();
    wr_data = 8'h3C; wr_valid = 1'b1; rd_en = 1'b1;
    tick();
    wr_valid = 1'b0; rd_en = 1'b0;
    chk("emptypop_count", count, 1);
    chk("emptypop_data", rd_data, 8'h3C);
    pop_once();
    chk("emptypop_drain", empty, 1);

    // Keep one byte resident so each pop must return the previous write.
    prev = 8'($urandom);
    send_byte(prev, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      nxt = 8'($urandom);
      wr_data = nxt; wr_valid = 1'b1; clr_overrun = k[0];
      tick();
      wr_valid = 1'b0; clr_overrun = 1'b0;
      chk("wrap_count2", count, 2);
      chk("wrap_data", rd_data, prev);
      pop_once();
      chk("wrap_count1", count, 1);
      prev = nxt;
    end
    chk("wrap_last", rd_data, prev);
    chk("wrap_ovr", overrun, 0);
    pop_once();
    chk("wrap_empty", empty, 1);

    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b0, 1'b1);
`ifdef RX_FIFO_ERRDROP_EN
    chk("errdrop_empty", empty, 1);
    chk("errdrop_cnt", err_cnt, 2);
`else
    chk("err_count", count, 2);
    chk("err_h1_data", rd_data, 8'h12);
    chk("err_h1_perr", rd_perr, 1);
    chk("err_h1_ferr", rd_ferr, 0);
    pop_once();
    chk("err_h2_data", rd_data, 8'h34);
    chk("err_h2_perr", rd_perr, 0);
    chk("err_h2_ferr", rd_ferr, 1);
    pop_once();
    chk("err_errcnt0", err_cnt, 0);
    chk("err_empty", empty, 1);
`endif

    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b0);
    chk("pre_rst_ovr", overrun, 1);
    for (int i = 0; i < 11; i++) pop_once();
    chk("pre_rst_count", count, 5);
    chk("pre_rst_head", rd_data, 8'h4B);
    enable_fifo = 1'b0;
    tick();
    enable_fifo = 1'b1;
    chk("midrst_empty", empty, 1);
    chk("midrst_count", count, 0);
    chk("midrst_ovr", overrun, 0);
    chk("midrst_full", full, 0);
    chk("midrst_errcnt", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
